// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: reset level,
// stall polarity, stage indices and control FSM encodings.
package pipe_stall_ctrl_pkg;

  localparam logic RESET_ENABLE = 1'b1;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic [1:0] CTRL_RUN   = 2'b00;
  localparam logic [1:0] CTRL_FLUSH = 2'b01;
  localparam logic [1:0] CTRL_HALT  = 2'b10;

endpackage

// File: rtl/pipe_stall_ctrl_stall_therm.sv
// Highest-set-bit to thermometer encoder: a stall in stage k also stalls every
// older stage below it, down to the PC.
module stall_therm
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [W-1:0] req,
  output logic [W-1:0] therm
);

  logic acc_s;

  // Running OR from the youngest stage downwards.
  always_comb begin
    acc_s = NO_STOP;
    therm = {W{NO_STOP}};
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i] == STOP) begin
        acc_s = STOP;
      end else begin
        acc_s = acc_s;
      end
      therm[i] = acc_s;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline control: thermometer stall vector, held flush with latched restart
// PC, debug halt, and a sticky watchdog on long stall runs.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int STAGES     = 6,
  parameter int PC_W       = 32,
  parameter int FLUSH_HOLD = 1,
  parameter int WDOG_LIMIT = 255,
  parameter int WDOG_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic              flush_req,
  input  logic [PC_W-1:0]   flush_pc,
  input  logic              halt_req,
  input  logic              timeout_clr,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [PC_W-1:0]   new_pc,
  output logic              stall_timeout
);

  localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(FLUSH_HOLD - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

  logic [1:0]        state_r, next_state_s;
  logic [HOLD_W-1:0] hold_cnt_r, next_cnt_s;
  logic [PC_W-1:0]   new_pc_r, next_pc_s;
  logic              flush_r;
  logic [WDOG_W-1:0] wdog_cnt_r;
  logic              timeout_r;
  logic              wdog_inc_s;
  logic [STAGES-1:0] therm_s;

  stall_therm #(.W(STAGES)) u_therm (
    .req   (stall_req),
    .therm (therm_s)
  );

  // Next-state, hold counter and restart-PC selection.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = hold_cnt_r;
    next_pc_s    = new_pc_r;
    case (state_r)
      CTRL_RUN: begin
        if (flush_req) begin
          next_state_s = CTRL_FLUSH;
          next_cnt_s   = HOLD_INIT;
          next_pc_s    = flush_pc;
        end else if (halt_req) begin
          next_state_s = CTRL_HALT;
        end else begin
          next_state_s = CTRL_RUN;
        end
      end
      CTRL_FLUSH: begin
        // A fresh request restarts the hold window; halt waits for RUN.
        if (flush_req) begin
          next_cnt_s = HOLD_INIT;
          next_pc_s  = flush_pc;
        end else if (hold_cnt_r == {HOLD_W{1'b0}}) begin
          next_state_s = CTRL_RUN;
        end else begin
          next_cnt_s = hold_cnt_r - HOLD_W'(1);
        end
      end
      CTRL_HALT: begin
        if (flush_req) begin
          next_state_s = CTRL_FLUSH;
          next_cnt_s   = HOLD_INIT;
          next_pc_s    = flush_pc;
        end else if (!halt_req) begin
          next_state_s = CTRL_RUN;
        end else begin
          next_state_s = CTRL_HALT;
        end
      end
      default: begin
        next_state_s = CTRL_RUN;
      end
    endcase
  end

  // Control state registers; flush is registered from the next state.
  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) begin
      state_r    <= CTRL_RUN;
      hold_cnt_r <= {HOLD_W{1'b0}};
      new_pc_r   <= {PC_W{1'b0}};
      flush_r    <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      hold_cnt_r <= next_cnt_s;
      new_pc_r   <= next_pc_s;
      flush_r    <= (next_state_s == CTRL_FLUSH);
    end
  end

  assign wdog_inc_s = (state_r == CTRL_RUN) && (stall_req != {STAGES{1'b0}});

  // Watchdog: count consecutive stalled RUN cycles, sticky flag at the limit.
  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
      timeout_r  <= 1'b0;
    end else begin
      if (!wdog_inc_s) begin
        wdog_cnt_r <= {WDOG_W{1'b0}};
      end else if (&wdog_cnt_r) begin
        wdog_cnt_r <= wdog_cnt_r;
      end else begin
        wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1);
      end
      if (wdog_inc_s && (wdog_cnt_r == WDOG_LAST)) begin
        timeout_r <= 1'b1;
      end else if (timeout_clr) begin
        timeout_r <= 1'b0;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end

  // Stall vector follows stall_req combinationally, gated by state and reset.
  always_comb begin
    stall = {STAGES{NO_STOP}};
    if (rst == RESET_ENABLE) begin
      stall = {STAGES{NO_STOP}};
    end else begin
      case (state_r)
        CTRL_RUN:   stall = therm_s;
        CTRL_FLUSH: stall = {STAGES{NO_STOP}};
        CTRL_HALT:  stall = {STAGES{STOP}};
        default:    stall = {STAGES{NO_STOP}};
      endcase
    end
  end

  assign flush         = flush_r;
  assign new_pc        = new_pc_r;
  assign stall_timeout = timeout_r;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with an event-level reference model
// checked every cycle plus literal spot checks.
module tb_pipe_stall_ctrl;

  localparam int STAGES     = 6;
  localparam int PC_W       = 32;
  localparam int FLUSH_HOLD = 2;
  localparam int WDOG_LIMIT = 4;
  localparam int WDOG_W     = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [STAGES-1:0] stall_req = 6'b001000;
  logic              flush_req = 1'b0;
  logic [PC_W-1:0]   flush_pc = 32'h0;
  logic              halt_req = 1'b0;
  logic              timeout_clr = 1'b0;
  logic [STAGES-1:0] stall;
  logic              flush;
  logic [PC_W-1:0]   new_pc;
  logic              stall_timeout;

  int vectors = 0;
  int errors  = 0;

  pipe_stall_ctrl #(
    .STAGES(STAGES), .PC_W(PC_W), .FLUSH_HOLD(FLUSH_HOLD),
    .WDOG_LIMIT(WDOG_LIMIT), .WDOG_W(WDOG_W)
  ) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .flush_pc(flush_pc), .halt_req(halt_req), .timeout_clr(timeout_clr),
    .stall(stall), .flush(flush), .new_pc(new_pc), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  // Reference model: flush window remaining, halted flag, latched pc,
  // length of the current stalled-RUN streak, sticky timeout.
  int          m_flush_left = 0;
  bit          m_halted = 1'b0;
  logic [31:0] m_pc = 32'h0;
  int          m_streak = 0;
  bit          m_to = 1'b0;
  bit          m_valid = 1'b0;

  function automatic logic [STAGES-1:0] exp_therm(input logic [STAGES-1:0] r);
    int k = -1;
    logic [STAGES:0] t;
    for (int i = 0; i < STAGES; i++) if (r[i]) k = i;
    if (k < 0) return '0;
    t = (7'd1 << (k + 1)) - 7'd1;
    return t[STAGES-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_flush_left = 0; m_halted = 1'b0; m_pc = 32'h0; m_streak = 0; m_to = 1'b0;
        m_valid = 1'b1;
      end else if (m_valid) begin
        if (m_flush_left == 0 && !m_halted && stall_req != '0) m_streak++;
        else m_streak = 0;
        if (m_streak == WDOG_LIMIT) m_to = 1'b1;
        else if (timeout_clr) m_to = 1'b0;
        if (flush_req) begin
          m_flush_left = FLUSH_HOLD; m_pc = flush_pc; m_halted = 1'b0;
        end else if (m_flush_left > 0) begin
          m_flush_left--;
        end else begin
          m_halted = halt_req;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("m_stall", 32'(stall),
              rst ? 32'h0 : (m_flush_left > 0) ? 32'h0 :
              m_halted ? 32'h3f : 32'(exp_therm(stall_req)));
        check("m_flush", 32'(flush), 32'(m_flush_left > 0));
        check("m_new_pc", new_pc, m_pc);
        check("m_timeout", 32'(stall_timeout), 32'(m_to));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  initial begin
    // reset with a pending stall request
    tick(2);
    at_neg();
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_new_pc", new_pc, 32'h0);
    check("rst_timeout", 32'(stall_timeout), 32'h0);
    tick();
    rst = 1'b0;

    // thermometer patterns
    stall_req = 6'b000100; at_neg(); check("therm_000100", 32'(stall), 32'h07); tick();
    stall_req = 6'b001100; at_neg(); check("therm_001100", 32'(stall), 32'h0f); tick();
    stall_req = 6'b100001; at_neg(); check("therm_100001", 32'(stall), 32'h3f); tick();
    stall_req = 6'b000000; at_neg(); check("therm_zero", 32'(stall), 32'h00); tick();

    // single flush
    stall_req = 6'b001000; flush_req = 1'b1; flush_pc = 32'h100;
    at_neg(); check("pre_flush_stall", 32'(stall), 32'h0f);
    tick(); flush_req = 1'b0;
    at_neg(); check("fl1_flush", 32'(flush), 32'h1); check("fl1_pc", new_pc, 32'h100);
    check("fl1_stall", 32'(stall), 32'h0);
    tick();
    at_neg(); check("fl2_flush", 32'(flush), 32'h1); check("fl2_stall", 32'(stall), 32'h0);
    tick();
    at_neg(); check("fl3_flush", 32'(flush), 32'h0); check("fl3_stall", 32'(stall), 32'h0f);

    // flush restarted by a second request
    flush_req = 1'b1; flush_pc = 32'h100; tick();
    flush_pc = 32'h200;
    at_neg(); check("rf1_pc", new_pc, 32'h100);
    tick(); flush_req = 1'b0;
    at_neg(); check("rf2_flush", 32'(flush), 32'h1); check("rf2_pc", new_pc, 32'h200);
    tick();
    at_neg(); check("rf3_flush", 32'(flush), 32'h1);
    tick();
    at_neg(); check("rf4_flush", 32'(flush), 32'h0); check("rf4_stall", 32'(stall), 32'h0f);
    check("rf4_pc", new_pc, 32'h200);
    stall_req = 6'b000000; tick();

    // halt held 3 edges, then released
    halt_req = 1'b1; stall_req = 6'b000010;
    at_neg(); check("halt0_stall", 32'(stall), 32'h03);
    tick();
    at_neg(); check("halt1_stall", 32'(stall), 32'h3f);
    tick(2);
    halt_req = 1'b0;
    at_neg(); check("halt3_stall", 32'(stall), 32'h3f);
    tick();
    at_neg(); check("halt_rel_stall", 32'(stall), 32'h03);

    // flush beats halt
    halt_req = 1'b1; tick(2);
    flush_req = 1'b1; flush_pc = 32'h300; tick();
    flush_req = 1'b0; halt_req = 1'b0;
    at_neg(); check("hf_flush", 32'(flush), 32'h1); check("hf_stall", 32'(stall), 32'h0);
    check("hf_pc", new_pc, 32'h300);
    tick(2);
    at_neg(); check("hf_run_stall", 32'(stall), 32'h03); check("hf_run_flush", 32'(flush), 32'h0);
    stall_req = 6'b000000; tick();

    // watchdog: 4 stalled cycles trip it
    stall_req = 6'b000100; tick(3);
    at_neg(); check("wd3_timeout", 32'(stall_timeout), 32'h0);
    tick(); stall_req = 6'b000000;
    at_neg(); check("wd4_timeout", 32'(stall_timeout), 32'h1);
    tick();
    at_neg(); check("wd_sticky", 32'(stall_timeout), 32'h1);
    timeout_clr = 1'b1; tick(); timeout_clr = 1'b0;
    at_neg(); check("wd_clr", 32'(stall_timeout), 32'h0);

    // broken streak does not trip
    stall_req = 6'b000100; tick(3);
    stall_req = 6'b000000; tick();
    stall_req = 6'b000100; tick(3);
    stall_req = 6'b000000;
    at_neg(); check("wd_broken", 32'(stall_timeout), 32'h0);
    tick();

    // set wins over a simultaneous clear
    stall_req = 6'b100000; timeout_clr = 1'b1; tick(4);
    stall_req = 6'b000000;
    at_neg(); check("wd_set_wins", 32'(stall_timeout), 32'h1);
    tick();
    at_neg(); check("wd_clr2", 32'(stall_timeout), 32'h0);
    timeout_clr = 1'b0; tick();

    // reset in the middle of a flush
    flush_req = 1'b1; flush_pc = 32'h400; tick();
    flush_req = 1'b0; rst = 1'b1;
    at_neg(); check("rf_rst_stall", 32'(stall), 32'h0);
    tick(); rst = 1'b0; stall_req = 6'b000100;
    at_neg(); check("rf_rst_flush", 32'(flush), 32'h0); check("rf_rst_pc", new_pc, 32'h0);
    check("rf_rst_stall2", 32'(stall), 32'h07);
    tick(); stall_req = 6'b000000; tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
